// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the hazard control unit.
//   - state_e  : sequencing FSM states, encoded as RUN=0 .. HALT=4
//   - REG_W    : register specifier width
//   - REG_ZERO : the hard-wired zero register, which never creates a hazard
package hazard_pkg;

    localparam int unsigned REG_W = 4;
    localparam logic [REG_W-1:0] REG_ZERO = 4'b0000;

    typedef enum logic [2:0] {
        StRun     = 3'd0,
        StMemWait = 3'd1,
        StFlush   = 3'd2,
        StDrain   = 3'd3,
        StHalt    = 3'd4
    } state_e;

endpackage

// File: rtl/hazard_control_unit_load_use_detect.sv
// load_use_detect: flags a load in execute whose destination is read by the
// instruction in decode. Purely combinational.
//   dx_memread, dx_rt       : load in execute and its destination register
//   fd_rs, fd_rt, fd_uses_rt: decode source registers and whether rt is read
//   load_use                : a one-bubble stall is required
module load_use_detect
    import hazard_pkg::*;
(
    input  logic             dx_memread,
    input  logic [REG_W-1:0] dx_rt,
    input  logic [REG_W-1:0] fd_rs,
    input  logic [REG_W-1:0] fd_rt,
    input  logic             fd_uses_rt,
    output logic             load_use
);

    assign load_use = dx_memread && (dx_rt != REG_ZERO) &&
                      ((dx_rt == fd_rs) || (fd_uses_rt && (dx_rt == fd_rt)));

endmodule

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: pipeline sequencing controller for the 5-stage CPU.
// Resolves hazards forwarding cannot: load-use, taken-branch flush, data
// memory wait and HLT drain, by driving PC / pipeline-register enables and
// flushes every cycle.
//   Inputs : clk, rst (sync, active-high), fd_rs, fd_rt, fd_uses_rt,
//            dx_memread, dx_rt, br_taken, halt_in, mem_req, mem_ready
//   Outputs: pc_write, fd_write, fd_flush, dx_write, dx_flush, xm_write,
//            halted, state (debug)
// Optional: define HAZARD_PERF_CNT_EN to add saturating stall_cnt, flush_cnt
//           and lu_cnt performance counters of width CNT_W.
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] fd_rs,
    input  logic [REG_W-1:0] fd_rt,
    input  logic             fd_uses_rt,
    input  logic             dx_memread,
    input  logic [REG_W-1:0] dx_rt,
    input  logic             br_taken,
    input  logic             halt_in,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             fd_write,
    output logic             fd_flush,
    output logic             dx_write,
    output logic             dx_flush,
    output logic             xm_write,
    output logic             halted,
`ifdef HAZARD_PERF_CNT_EN
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] lu_cnt,
`endif
    output logic [2:0]       state
);

    localparam logic [2:0] FlushInit = 3'(FLUSH_CYCLES - 1);
    localparam logic [2:0] DrainInit = 3'(DRAIN_CYCLES - 1);

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       load_use;
    logic       mem_stall;
    logic       lu_bubble;  // load-use bubble issued this cycle
    logic       br_flush;   // dx_flush caused by a taken branch

    load_use_detect u_load_use_detect (
        .dx_memread (dx_memread),
        .dx_rt      (dx_rt),
        .fd_rs      (fd_rs),
        .fd_rt      (fd_rt),
        .fd_uses_rt (fd_uses_rt),
        .load_use   (load_use)
    );

    assign mem_stall = mem_req && !mem_ready;
    assign state     = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        pc_write  = 1'b1;
        fd_write  = 1'b1;
        dx_write  = 1'b1;
        xm_write  = 1'b1;
        fd_flush  = 1'b0;
        dx_flush  = 1'b0;
        halted    = 1'b0;
        lu_bubble = 1'b0;
        br_flush  = 1'b0;
        state_d   = state_q;
        cnt_d     = cnt_q;

        case (state_q)
            StRun: begin
                if (mem_stall) begin
                    pc_write = 1'b0;
                    fd_write = 1'b0;
                    dx_write = 1'b0;
                    xm_write = 1'b0;
                    state_d  = StMemWait;
                end else if (br_taken) begin
                    fd_flush = 1'b1;
                    dx_flush = 1'b1;
                    br_flush = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = StFlush;
                        cnt_d   = FlushInit;
                    end
                end else if (load_use) begin
                    pc_write  = 1'b0;
                    fd_write  = 1'b0;
                    dx_flush  = 1'b1;
                    lu_bubble = 1'b1;
                end else if (halt_in) begin
                    pc_write = 1'b0;
                    fd_flush = 1'b1;
                    state_d  = StDrain;
                    cnt_d    = DrainInit;
                end
            end
            StMemWait: begin
                // Stages frozen; pending branch/load-use/halt re-evaluate in RUN.
                if (!mem_ready) begin
                    pc_write = 1'b0;
                    fd_write = 1'b0;
                    dx_write = 1'b0;
                    xm_write = 1'b0;
                end else begin
                    state_d = StRun;
                end
            end
            StFlush: begin
                fd_flush = 1'b1;
                dx_flush = 1'b1;
                br_flush = 1'b1;
                if (cnt_q <= 3'd1) begin
                    state_d = StRun;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StDrain: begin
                pc_write = 1'b0;
                fd_write = 1'b0;
                fd_flush = 1'b1;
                dx_flush = 1'b1;
                if (mem_stall) begin
                    xm_write = 1'b0;  // hold the drain count while memory stalls
                end else if (cnt_q == 3'd0) begin
                    state_d = StHalt;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StHalt: begin
                pc_write = 1'b0;
                fd_write = 1'b0;
                dx_write = 1'b0;
                xm_write = 1'b0;
                halted   = 1'b1;
            end
            default: begin
                state_d = StRun;
                cnt_d   = 3'd0;
            end
        endcase

        if (rst) begin
            pc_write  = 1'b0;
            fd_write  = 1'b0;
            dx_write  = 1'b0;
            xm_write  = 1'b0;
            fd_flush  = 1'b1;
            dx_flush  = 1'b1;
            halted    = 1'b0;
            lu_bubble = 1'b0;
            br_flush  = 1'b0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic stall_evt;
    assign stall_evt = !rst && !pc_write && ((state_q == StRun) || (state_q == StMemWait));

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            lu_cnt    <= '0;
        end else begin
            if (stall_evt && (stall_cnt != CntMax)) stall_cnt <= stall_cnt + 1'b1;
            if (br_flush && (flush_cnt != CntMax))  flush_cnt <= flush_cnt + 1'b1;
            if (lu_bubble && (lu_cnt != CntMax))    lu_cnt    <= lu_cnt + 1'b1;
        end
    end
`endif

endmodule
